// File: rtl/hoplite_traffic_gen.sv
// hoplite_traffic_gen
//    Per-node packet source for the Hoplite torus test fabric. Emits MEM_D
//    deterministic packets toward the router PE injection port, paced by a
//    token bucket (one token every MAX_RATE cycles, up to MAX_TOKEN stored).
//
// Ports
//    clk          clock, all state on rising edge
//    rst          asynchronous active-high reset
//    o_v          packet valid toward router PE port
//    o_rdy        router accepts the PE packet this cycle
//    o_d          payload {src, seq}
//    o_x, o_y     destination coordinates
//    done         all MEM_D packets accepted (sticky)
//    sent_count   packets accepted so far
//    stall_count  cycles with o_v=1 and o_rdy=0, saturating
module hoplite_traffic_gen #(
   parameter int D_W       = 16,
   parameter int X_DIM     = 4,
   parameter int Y_DIM     = 4,
   parameter int X         = 0,
   parameter int Y         = 0,
   parameter int MAX_RATE  = 5,
   parameter int MAX_TOKEN = 2,
   parameter int MEM_D     = 20,
   localparam int XW = (X_DIM > 1) ? $clog2(X_DIM) : 1,
   localparam int YW = (Y_DIM > 1) ? $clog2(Y_DIM) : 1,
   localparam int SW = $clog2(MEM_D + 1)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          o_v,
   input  logic          o_rdy,
   output logic [D_W-1:0] o_d,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y,
   output logic          done,
   output logic [SW-1:0] sent_count,
   output logic [15:0]   stall_count
);

   localparam int HW  = D_W / 2;
   localparam int RW  = (MAX_RATE > 1) ? $clog2(MAX_RATE) : 1;
   localparam int TW  = $clog2(MAX_TOKEN + 1);
   localparam int SRC = X + Y * X_DIM;

   // Reset destination is the node right after ourselves in row-major order.
   localparam int RST_X = (X == X_DIM - 1) ? 0 : X + 1;
   localparam int RST_Y = (X == X_DIM - 1) ? ((Y == Y_DIM - 1) ? 0 : Y + 1) : Y;

   localparam logic [HW-1:0] SRC_H = HW'(SRC);

   logic [RW-1:0] rate_cnt_q, rate_cnt_d;
   logic [TW-1:0] tokens_q, tokens_d;
   logic [SW-1:0] seq_q, seq_d;
   logic [XW-1:0] dest_x_q, dest_x_d;
   logic [YW-1:0] dest_y_q, dest_y_d;
   logic          done_q, done_d;
   logic [15:0]   stall_q, stall_d;

   logic          refill;
   logic          acc;
   logic          valid;
   logic [XW-1:0] x1, x2;
   logic [YW-1:0] y1, y2;

   assign refill = (rate_cnt_q == RW'(MAX_RATE - 1));
   assign valid  = (tokens_q != '0) && (seq_q != SW'(MEM_D));
   assign acc    = valid & o_rdy;

   // Destination is kept as (x, y) counters so no divide/modulo by the
   // torus dimensions is needed. Two candidate steps are computed; the
   // second is used only when the first lands on our own node.
   always_comb begin
      x1 = dest_x_q;
      y1 = dest_y_q;
      if (dest_x_q == XW'(X_DIM - 1)) begin
         x1 = '0;
         y1 = (dest_y_q == YW'(Y_DIM - 1)) ? '0 : dest_y_q + 1'b1;
      end else begin
         x1 = dest_x_q + 1'b1;
      end

      x2 = x1;
      y2 = y1;
      if (x1 == XW'(X_DIM - 1)) begin
         x2 = '0;
         y2 = (y1 == YW'(Y_DIM - 1)) ? '0 : y1 + 1'b1;
      end else begin
         x2 = x1 + 1'b1;
      end
   end

   always_comb begin
      rate_cnt_d = refill ? '0 : rate_cnt_q + 1'b1;

      // Refill and accept in the same cycle cancel; a refill into a full
      // bucket is dropped.
      tokens_d = tokens_q;
      if (refill && !acc) begin
         if (tokens_q != TW'(MAX_TOKEN)) tokens_d = tokens_q + 1'b1;
      end else if (!refill && acc) begin
         tokens_d = tokens_q - 1'b1;
      end

      seq_d    = seq_q;
      dest_x_d = dest_x_q;
      dest_y_d = dest_y_q;
      done_d   = done_q;
      if (acc) begin
         seq_d = seq_q + 1'b1;
         if (seq_q == SW'(MEM_D - 1)) done_d = 1'b1;
         if ((x1 == XW'(X)) && (y1 == YW'(Y))) begin
            dest_x_d = x2;
            dest_y_d = y2;
         end else begin
            dest_x_d = x1;
            dest_y_d = y1;
         end
      end

      stall_d = stall_q;
      if (valid && !o_rdy && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rate_cnt_q <= '0;
         tokens_q   <= '0;
         seq_q      <= '0;
         dest_x_q   <= XW'(RST_X);
         dest_y_q   <= YW'(RST_Y);
         done_q     <= 1'b0;
         stall_q    <= '0;
      end else begin
         rate_cnt_q <= rate_cnt_d;
         tokens_q   <= tokens_d;
         seq_q      <= seq_d;
         dest_x_q   <= dest_x_d;
         dest_y_q   <= dest_y_d;
         done_q     <= done_d;
         stall_q    <= stall_d;
      end
   end

   // Packet fields come straight from registers, so they cannot move while
   // a packet waits for acceptance.
   assign o_v         = valid;
   assign o_d         = {SRC_H, HW'(seq_q)};
   assign o_x         = dest_x_q;
   assign o_y         = dest_y_q;
   assign done        = done_q;
   assign sent_count  = seq_q;
   assign stall_count = stall_q;

endmodule

// File: tb/tb_hoplite_traffic_gen.sv
// Testbench for hoplite_traffic_gen: three instances (default node 0,
// node (2,1), and a MAX_RATE=1/MAX_TOKEN=1 variant) exercised by directed
// scenarios with hand-computed expected values.
module tb_hoplite_traffic_gen;

   logic        clk;
   logic        rst_a, rdy_a, v_a, done_a;
   logic [15:0] d_a, stall_a;
   logic [1:0]  x_a, y_a;
   logic [4:0]  sent_a;

   logic        rst_b, rdy_b, v_b, done_b;
   logic [15:0] d_b, stall_b;
   logic [1:0]  x_b, y_b;
   logic [4:0]  sent_b;

   logic        rst_c, rdy_c, v_c, done_c;
   logic [15:0] d_c, stall_c;
   logic [1:0]  x_c, y_c;
   logic [4:0]  sent_c;

   int checks = 0;
   int errors = 0;

   // Destination indices for the 20 packets of node 0 and node 6.
   int dst_a[20] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 1, 2, 3, 4, 5};
   int dst_b[20] = '{7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4, 5, 7, 8, 9, 10, 11};

   hoplite_traffic_gen u_a (
      .clk(clk), .rst(rst_a), .o_v(v_a), .o_rdy(rdy_a), .o_d(d_a), .o_x(x_a), .o_y(y_a),
      .done(done_a), .sent_count(sent_a), .stall_count(stall_a)
   );

   hoplite_traffic_gen #(.X(2), .Y(1)) u_b (
      .clk(clk), .rst(rst_b), .o_v(v_b), .o_rdy(rdy_b), .o_d(d_b), .o_x(x_b), .o_y(y_b),
      .done(done_b), .sent_count(sent_b), .stall_count(stall_b)
   );

   hoplite_traffic_gen #(.MAX_RATE(1), .MAX_TOKEN(1)) u_c (
      .clk(clk), .rst(rst_c), .o_v(v_c), .o_rdy(rdy_c), .o_d(d_c), .o_x(x_c), .o_y(y_c),
      .done(done_c), .sent_count(sent_c), .stall_count(stall_c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rdy_a = 1'b1;
      tick();
      tick();
      checks++;
      if (v_a !== 1'b0 || d_a !== 16'h0000 || x_a !== 2'd1 || y_a !== 2'd0) begin
         errors++;
         $display("FAIL reset_pkt: v=%b d=%h x=%0d y=%0d expected v=0 d=0000 x=1 y=0", v_a, d_a, x_a, y_a);
      end
      checks++;
      if (done_a !== 1'b0 || sent_a !== 5'd0 || stall_a !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt: done=%b sent=%0d stall=%0d expected 0 0 0", done_a, sent_a, stall_a);
      end
      rst_a = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i >= 4) begin
            checks++;
            if (v_a !== (i == 5)) begin
               errors++;
               $display("FAIL first_valid edge %0d: o_v=%b expected %b", i, v_a, (i == 5));
            end
         end
      end
   endtask

   task automatic test_stream();
      int n;
      int hi;
      logic [1:0] ex, ey;
      for (int p = 0; p < 20; p++) begin
         n = 0;
         while (v_a !== 1'b1 && n < 12) begin tick(); n++; end
         checks++;
         if (v_a !== 1'b1) begin
            errors++;
            $display("FAIL stream_valid pkt %0d: o_v=%b expected 1", p, v_a);
         end
         if (p > 0) begin
            checks++;
            if (n != 4) begin
               errors++;
               $display("FAIL stream_gap pkt %0d: idle cycles %0d expected 4", p, n);
            end
         end
         ex = 2'(dst_a[p] % 4);
         ey = 2'(dst_a[p] / 4);
         checks++;
         if (d_a !== 16'(p) || x_a !== ex || y_a !== ey) begin
            errors++;
            $display("FAIL stream_pkt %0d: d=%h x=%0d y=%0d expected d=%h x=%0d y=%0d",
                     p, d_a, x_a, y_a, 16'(p), ex, ey);
         end
         tick();
         checks++;
         if (sent_a !== 5'(p + 1)) begin
            errors++;
            $display("FAIL stream_sent pkt %0d: sent=%0d expected %0d", p, sent_a, p + 1);
         end
      end
      checks++;
      if (done_a !== 1'b1 || sent_a !== 5'd20) begin
         errors++;
         $display("FAIL stream_done: done=%b sent=%0d expected 1 20", done_a, sent_a);
      end
      hi = 0;
      for (int i = 0; i < 15; i++) begin
         if (v_a !== 1'b0) hi++;
         tick();
      end
      checks++;
      if (hi != 0 || done_a !== 1'b1) begin
         errors++;
         $display("FAIL stream_after_done: o_v high %0d cycles done=%b expected 0 cycles done=1", hi, done_a);
      end
   endtask

   task automatic test_burst();
      int cnt;
      int n;
      rst_a = 1'b1;
      rdy_a = 1'b0;
      tick();
      rst_a = 1'b0;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (v_a === 1'b1) cnt++;
         tick();
      end
      checks++;
      if (cnt != 25 || stall_a !== 16'd25) begin
         errors++;
         $display("FAIL burst_stall: stall=%0d valid_cycles=%0d expected 25 25", stall_a, cnt);
      end
      rdy_a = 1'b1;
      checks++;
      if (v_a !== 1'b1 || d_a !== 16'h0000) begin
         errors++;
         $display("FAIL burst_first: v=%b d=%h expected 1 0000", v_a, d_a);
      end
      tick();
      checks++;
      if (v_a !== 1'b1 || d_a !== 16'h0001 || sent_a !== 5'd1) begin
         errors++;
         $display("FAIL burst_second: v=%b d=%h sent=%0d expected 1 0001 1", v_a, d_a, sent_a);
      end
      tick();
      checks++;
      if (v_a !== 1'b0 || sent_a !== 5'd2) begin
         errors++;
         $display("FAIL burst_empty: v=%b sent=%0d expected 0 2", v_a, sent_a);
      end
      n = 0;
      while (v_a !== 1'b1 && n < 12) begin tick(); n++; end
      checks++;
      if (n != 3 || d_a !== 16'h0002) begin
         errors++;
         $display("FAIL burst_refill: wait=%0d d=%h expected 3 0002", n, d_a);
      end
      tick();
      n = 0;
      while (v_a !== 1'b1 && n < 12) begin tick(); n++; end
      checks++;
      if (n != 4 || d_a !== 16'h0003 || stall_a !== 16'd25) begin
         errors++;
         $display("FAIL burst_steady: wait=%0d d=%h stall=%0d expected 4 0003 25", n, d_a, stall_a);
      end
   endtask

   task automatic test_hold();
      int acc_n;
      logic prev_v, prev_rdy, r;
      logic [15:0] pd;
      logic [1:0] px, py, ex, ey;
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      acc_n = 0;
      prev_v = 1'b0;
      prev_rdy = 1'b1;
      pd = '0; px = '0; py = '0;
      for (int cyc = 0; cyc < 600 && acc_n < 20; cyc++) begin
         if (prev_v && !prev_rdy) begin
            checks++;
            if (v_a !== 1'b1 || d_a !== pd || x_a !== px || y_a !== py) begin
               errors++;
               $display("FAIL hold cycle %0d: v=%b d=%h x=%0d y=%0d expected 1 %h %0d %0d",
                        cyc, v_a, d_a, x_a, y_a, pd, px, py);
            end
         end
         r = 1'($urandom_range(0, 1));
         rdy_a = r;
         if (v_a === 1'b1 && r) begin
            ex = 2'(dst_a[acc_n] % 4);
            ey = 2'(dst_a[acc_n] / 4);
            checks++;
            if (d_a !== 16'(acc_n) || x_a !== ex || y_a !== ey) begin
               errors++;
               $display("FAIL hold_accept %0d: d=%h x=%0d y=%0d expected %h %0d %0d",
                        acc_n, d_a, x_a, y_a, 16'(acc_n), ex, ey);
            end
            acc_n++;
         end
         prev_v = v_a; prev_rdy = r; pd = d_a; px = x_a; py = y_a;
         tick();
      end
      checks++;
      if (acc_n != 20 || sent_a !== 5'd20 || done_a !== 1'b1) begin
         errors++;
         $display("FAIL hold_total: accepts=%0d sent=%0d done=%b expected 20 20 1", acc_n, sent_a, done_a);
      end
      rdy_a = 1'b1;
   endtask

   task automatic test_node();
      int n;
      logic [1:0] ex, ey;
      rdy_b = 1'b1;
      checks++;
      if (v_b !== 1'b0 || d_b !== 16'h0600 || x_b !== 2'd3 || y_b !== 2'd1) begin
         errors++;
         $display("FAIL node_reset: v=%b d=%h x=%0d y=%0d expected 0 0600 3 1", v_b, d_b, x_b, y_b);
      end
      rst_b = 1'b0;
      for (int p = 0; p < 20; p++) begin
         n = 0;
         while (v_b !== 1'b1 && n < 12) begin tick(); n++; end
         ex = 2'(dst_b[p] % 4);
         ey = 2'(dst_b[p] / 4);
         checks++;
         if (v_b !== 1'b1 || d_b[15:8] !== 8'h06 || d_b[7:0] !== 8'(p) || x_b !== ex || y_b !== ey) begin
            errors++;
            $display("FAIL node_pkt %0d: v=%b d=%h x=%0d y=%0d expected 1 %h %0d %0d",
                     p, v_b, d_b, x_b, y_b, {8'h06, 8'(p)}, ex, ey);
         end
         tick();
      end
      checks++;
      if (done_b !== 1'b1 || sent_b !== 5'd20) begin
         errors++;
         $display("FAIL node_done: done=%b sent=%0d expected 1 20", done_b, sent_b);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      rst_a = 1'b1;
      rdy_a = 1'b1;
      tick();
      rst_a = 1'b0;
      n = 0;
      while (sent_a !== 5'd7 && n < 100) begin tick(); n++; end
      n = 0;
      while (v_a !== 1'b1 && n < 12) begin tick(); n++; end
      checks++;
      if (v_a !== 1'b1 || d_a !== 16'h0007) begin
         errors++;
         $display("FAIL mid_before: v=%b d=%h expected 1 0007", v_a, d_a);
      end
      #2;
      rst_a = 1'b1;
      #1;
      checks++;
      if (v_a !== 1'b0 || d_a !== 16'h0000 || x_a !== 2'd1 || y_a !== 2'd0 || sent_a !== 5'd0) begin
         errors++;
         $display("FAIL mid_async: v=%b d=%h x=%0d y=%0d sent=%0d expected 0 0000 1 0 0",
                  v_a, d_a, x_a, y_a, sent_a);
      end
      tick();
      rst_a = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i >= 4) begin
            checks++;
            if (v_a !== (i == 5) || d_a !== 16'h0000) begin
               errors++;
               $display("FAIL mid_restart edge %0d: v=%b d=%h expected %b 0000", i, v_a, d_a, (i == 5));
            end
         end
      end
   endtask

   task automatic test_rate1();
      rdy_c = 1'b1;
      rst_c = 1'b0;
      checks++;
      if (v_c !== 1'b0) begin
         errors++;
         $display("FAIL rate1_cycle1: o_v=%b expected 0", v_c);
      end
      tick();
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (v_c !== 1'b1 || d_c !== 16'(k)) begin
            errors++;
            $display("FAIL rate1_pkt %0d: v=%b d=%h expected 1 %h", k, v_c, d_c, 16'(k));
         end
         tick();
      end
      checks++;
      if (v_c !== 1'b0 || done_c !== 1'b1 || sent_c !== 5'd20 || stall_c !== 16'd0) begin
         errors++;
         $display("FAIL rate1_end: v=%b done=%b sent=%0d stall=%0d expected 0 1 20 0",
                  v_c, done_c, sent_c, stall_c);
      end
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
      test_reset();
      test_stream();
      test_burst();
      test_hold();
      test_node();
      test_reset_mid();
      test_rate1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hoplite_traffic_gen.md
# hoplite_traffic_gen

Per-node packet source for the Hoplite torus test fabric. One instance sits at each (X, Y) node of the torus bench, directly upstream of that node's router processing-element (PE) injection port. It generates a fixed, deterministic sequence of MEM_D packets, shaped by a token-bucket rate limiter (one token per MAX_RATE cycles, burst up to MAX_TOKEN). It exposes progress and back-pressure counters for the bench's end-of-run checks.

## Interface
- D_W, 16: payload width; must be ≥ 2·clog2(max(MEM_D, X_DIM·Y_DIM)).
- X_DIM, 4: torus X dimension (≥1).
- Y_DIM, 4: torus Y dimension (≥1); X_DIM·Y_DIM ≥ 2.
- X, 0: this node's X coordinate.
- Y, 0: this node's Y coordinate.
- MAX_RATE, 5: cycles per token refill (≥1).
- MAX_TOKEN, 2: bucket capacity (≥1).
- MEM_D, 20: packets to send.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- o_v  out  1  packet valid toward router PE port.
- o_rdy  in  1  router accepts PE packet this cycle.
- o_d  out  D_W  payload.
- o_x  out  clog2(X_DIM)  destination X.
- o_y  out  clog2(Y_DIM)  destination Y.
- done  out  1  all MEM_D packets accepted.
- sent_count  out  clog2(MEM_D+1)  packets accepted so far.
- stall_count  out  16  cycles with o_v=1 and o_rdy=0, saturating at 16'hFFFF.

## Operation
- State registers:
  - rate_cnt: 0..MAX_RATE-1.
  - tokens: 0..MAX_TOKEN.
  - seq: 0..MEM_D; sent_count = seq.
  - dest: 0..N-1, where N = X_DIM·Y_DIM.
  - stall_count.
- Node index: src = X + Y·X_DIM.
- Refill:
  - refill = (rate_cnt == MAX_RATE-1).
  - rate_cnt wraps to 0 on refill, otherwise increments.
  - rate_cnt runs continuously, including after done.
- Accept: acc = o_v & o_rdy.
- Token update: tokens_next = min(tokens + refill − acc, MAX_TOKEN).
  - Refill and accept in the same cycle cancel.
  - Refill at a full bucket with no accept is lost.
- o_v = (tokens != 0) & (seq != MEM_D). It is combinational from registers only and has no dependence on o_rdy.
- Packet contents depend only on seq and dest:
  - o_d upper D_W/2 bits = src.
  - o_d lower D_W/2 bits = seq.
  - o_x = dest mod X_DIM, o_y = dest / X_DIM.
- Destination sequence: first packet goes to (src+1) mod N. Each accept advances dest by 1 mod N, skipping src. The generator never targets itself.
- Hold rule: once o_v rises, o_v/o_d/o_x/o_y stay constant until the accept cycle. tokens never drops without acc, so o_v cannot fall early.
- Completion:
  - After the MEM_D-th accept, seq = MEM_D, o_v = 0 permanently and done = 1 (registered, sticky until reset).
  - tokens keeps accumulating up to MAX_TOKEN; this is harmless.
- stall_count increments when o_v & ~o_rdy and holds at 16'hFFFF.
- o_rdy while o_v = 0 is ignored.

## Timing
- Reset values:
  - o_v = 0, o_d = {src, 0}, o_x/o_y = coordinates of (src+1) mod N.
  - done = 0, sent_count = 0, stall_count = 0.
  - tokens = 0, rate_cnt = 0, seq = 0.
- First o_v: after reset deasserts, the MAX_RATE-th rising edge sets tokens = 1, and o_v is high in the following cycle.
- Accept latency: acc on edge k updates seq, dest, tokens and sent_count at edge k. The next packet is presented in cycle k+1 if tokens remain. A full bucket therefore gives MAX_TOKEN back-to-back packets.
- Throughput: with o_rdy tied high, steady state is 1 packet per MAX_RATE cycles.
- Reset mid-operation: all state clears immediately and asynchronously, and o_v drops in the same cycle. The sequence restarts from seq 0 after release.

## Test plan
- Defaults, X=0, Y=0, o_rdy=1, rst released at t0:
  - o_v first high after 5 edges.
  - One packet every 5 cycles.
  - Payloads 16'h0000..16'h0013.
  - Destinations (1,0),(2,0),(3,0),(0,1)…(3,3),(1,0)…; node 0 is never a destination.
  - done=1 and sent_count=20 after the 20th accept; o_v stays 0 afterwards.
- Burst: o_rdy=0 for 30 cycles, then 1:
  - tokens saturate at 2; exactly 2 back-to-back accepts, then spacing of 5.
  - stall_count equals the number of cycles with o_v=1 during the hold.
- Hold: toggle o_rdy randomly:
  - o_d/o_x/o_y never change while o_v=1 and o_rdy=0.
  - No packet lost or duplicated; seq is contiguous 0..19.
- Node X=2, Y=1 (src=6):
  - Upper payload byte = 8'h06.
  - First destination (3,1); the destination after (1,1), i.e. index 5, is (3,1), skipping 6.
- Reset pulse asserted mid-run after packet 7:
  - Outputs return to reset values asynchronously.
  - After release, seq restarts at 0 and the first o_v appears 5 edges later.
- MAX_RATE=1, MAX_TOKEN=1, o_rdy=1:
  - o_v high from cycle 2 and continuously.
  - 20 packets in 20 consecutive cycles.
  - stall_count=0.
